rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file with per-register rename status (busy bit plus ROB tag) for the Tomasulo core.
- Sits at the receiving end of the ROB commit interface: it accepts retired results and busy-release requests, and returns busy/tag status for the register being committed.
- Also serves dispatch: two source-operand lookups and one destination-rename write per cycle.
- Flush (clear) drops all renames.

Parameters:
- ROB_IDX_W, 4, width of a ROB tag (16-entry ROB).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- rdy  input  1  global enable; low freezes all state
- clear  input  1  misprediction flush
- commit_we  input  1  write commit_data into commit_rd
- commit_rd  input  5  committed destination register
- commit_data  input  XLEN  committed value
- commit_release  input  1  clear busy of commit_rd (qualified by commit_we)
- commit_busy  output  1  current busy bit of commit_rd
- commit_tag  output  ROB_IDX_W  current tag of commit_rd
- rename_we  input  1  mark rename_rd busy
- rename_rd  input  5  destination being renamed
- rename_tag  input  ROB_IDX_W  ROB entry allocated for rename_rd
- rs1_addr  input  5  operand 1 index
- rs1_value  output  XLEN  operand 1 value
- rs1_busy  output  1  operand 1 pending
- rs1_tag  output  ROB_IDX_W  producer tag of operand 1
- rs2_addr  input  5  operand 2 index
- rs2_value  output  XLEN  operand 2 value
- rs2_busy  output  1  operand 2 pending
- rs2_tag  output  ROB_IDX_W  producer tag of operand 2

Behaviour:
- State: value[31:0], busy[31:0], tag[31:0]. On reset all are zero, so every output reads 0.
- x0: writes and renames to register 0 are ignored. x0 always reads value 0, busy 0, tag 0.
- Updates happen at posedge when rst=0 and rdy=1. With rdy=0, state holds; outputs still track the inputs combinationally.
- Commit write: commit_we with commit_rd!=0 sets value[commit_rd] <= commit_data, regardless of busy or tag.
- Busy release: commit_we & commit_release with commit_rd!=0 sets busy[commit_rd] <= 0. The tag is left unchanged. The ROB asserts release only when commit_busy=1 and commit_tag equals its head index; the block does not re-check.
- Rename: rename_we with rename_rd!=0 sets busy <= 1 and tag <= rename_tag.
- Same-cycle rename and release of the same register: rename wins (busy=1, new tag). The value write from the commit still occurs.
- clear: all busy bits <= 0 and tags are retained. A commit write in the same cycle is still applied (JALR retires on the flush cycle). A rename in the same cycle is dropped.
- rst has priority over rdy. rdy has priority over clear.
- commit_busy/commit_tag: combinational from registered state for commit_rd. No bypass.
- Read ports: combinational, with zero-cycle latency from state.
  - A same-cycle rename never affects the read ports; the dispatching instruction sees its sources before its own rename.
  - Bypass per COMMIT_BYPASS_EN below.
- Widths: tags are stored as ROB_IDX_W bits. Indices are 5 bits; no wrap logic is needed.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: if commit_we, rsX_addr==commit_rd and rsX_addr!=0, then rsX_value = commit_data.
  - If commit_release is also set and clear=0, rsX_busy = 0.
  - Otherwise busy/tag come from state.
- Undefined: read ports reflect registered state only, so the committed value is visible the cycle after commit.

Test Plan:
- Reset then read x5 -> value 0, busy 0, tag 0; also commit_busy 0.
- Rename x5 tag 3 at cycle 1; read x5 at cycle 2 -> busy 1, tag 3. At cycle 1 the read still shows busy 0.
- Commit x5 = 0xDEADBEEF with release at cycle 3 -> cycle 4 read shows value 0xDEADBEEF, busy 0. With bypass enabled, cycle 3 already shows 0xDEADBEEF, busy 0.
- Same cycle: rename x7 tag 9 plus commit x7 = 0x11 with release -> next cycle busy 1, tag 9, value 0x11.
- Rename x1 tag 2 and x2 tag 4, then clear together with commit x1 = 0x40 -> busy 0 for x1 and x2, x1 value 0x40. A rename of x3 in the clear cycle is dropped (busy 0).
- Writes/renames to x0 with data 0xFFFFFFFF -> x0 reads 0/0/0. With rdy=0, a commit to x4 is ignored and x4 is unchanged after rdy rises.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Define RF_COMMIT_BYPASS_EN to forward the committing value to the read ports.
module rename_regfile #(
  parameter int ROB_IDX_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 commit_we,
  input  logic [4:0]           commit_rd,
  input  logic [XLEN-1:0]      commit_data,
  input  logic                 commit_release,
  output logic                 commit_busy,
  output logic [ROB_IDX_W-1:0] commit_tag,
  input  logic                 rename_we,
  input  logic [4:0]           rename_rd,
  input  logic [ROB_IDX_W-1:0] rename_tag,
  input  logic [4:0]           rs1_addr,
  output logic [XLEN-1:0]      rs1_value,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs2_value,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_tag
);

  logic [XLEN-1:0]      value [32];
  logic [ROB_IDX_W-1:0] tag   [32];
  logic [31:0]          busy;

  logic commit_hit;
  logic rename_hit;

  assign commit_hit = commit_we && (commit_rd != 5'd0);
  assign rename_hit = rename_we && (rename_rd != 5'd0);

  // Later assignments win: a rename overrides a same-cycle release, and clear
  // overrides both while still letting the commit value land.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < 32; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_hit) begin
        value[commit_rd] <= commit_data;
        if (commit_release)
          busy[commit_rd] <= 1'b0;
      end
      if (clear) begin
        busy <= '0;
      end else if (rename_hit) begin
        busy[rename_rd] <= 1'b1;
        tag[rename_rd]  <= rename_tag;
      end
    end
  end

  assign commit_busy = busy[commit_rd];
  assign commit_tag  = tag[commit_rd];

  always_comb begin
    rs1_value = '0;
    rs1_busy  = 1'b0;
    rs1_tag   = '0;
    if (rs1_addr != 5'd0) begin
      rs1_value = value[rs1_addr];
      rs1_busy  = busy[rs1_addr];
      rs1_tag   = tag[rs1_addr];
`ifdef RF_COMMIT_BYPASS_EN
      if (commit_we && (rs1_addr == commit_rd)) begin
        rs1_value = commit_data;
        if (commit_release && !clear)
          rs1_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rs2_value = '0;
    rs2_busy  = 1'b0;
    rs2_tag   = '0;
    if (rs2_addr != 5'd0) begin
      rs2_value = value[rs2_addr];
      rs2_busy  = busy[rs2_addr];
      rs2_tag   = tag[rs2_addr];
`ifdef RF_COMMIT_BYPASS_EN
      if (commit_we && (rs2_addr == commit_rd)) begin
        rs2_value = commit_data;
        if (commit_release && !clear)
          rs2_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed steps then random traffic
// against an array-based reference model of the register file.
module tb_rename_regfile;

  localparam int ROB_IDX_W = 4;
  localparam int XLEN      = 32;

  logic                 clk = 1'b0;
  logic                 rst, rdy, clear;
  logic                 commit_we, commit_release, rename_we;
  logic [4:0]           commit_rd, rename_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0]      commit_data;
  logic [ROB_IDX_W-1:0] rename_tag;
  logic                 commit_busy, rs1_busy, rs2_busy;
  logic [ROB_IDX_W-1:0] commit_tag, rs1_tag, rs2_tag;
  logic [XLEN-1:0]      rs1_value, rs2_value;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]      m_val [32];
  logic                 m_bsy [32];
  logic [ROB_IDX_W-1:0] m_tag [32];

  rename_regfile #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_release(commit_release), .commit_busy(commit_busy), .commit_tag(commit_tag),
    .rename_we(rename_we), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rs1_addr(rs1_addr), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_addr(rs2_addr), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );

  always #5 clk = ~clk;

  function automatic logic bypass_on();
`ifdef RF_COMMIT_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] exp_value(input logic [4:0] a);
    if (a == 0) return '0;
    if (bypass_on() && commit_we && a == commit_rd) return commit_data;
    return m_val[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (bypass_on() && commit_we && a == commit_rd && commit_release && !clear) return 1'b0;
    return m_bsy[a];
  endfunction

  function automatic logic [ROB_IDX_W-1:0] exp_tag(input logic [4:0] a);
    if (a == 0) return '0;
    return m_tag[a];
  endfunction

  task automatic check_eq(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic cl,
                               input logic cwe, input logic [4:0] crd,
                               input logic [XLEN-1:0] cdata, input logic crel,
                               input logic rwe, input logic [4:0] rrd,
                               input logic [ROB_IDX_W-1:0] rtag,
                               input logic [4:0] a1, input logic [4:0] a2);
    rst = r; rdy = en; clear = cl;
    commit_we = cwe; commit_rd = crd; commit_data = cdata; commit_release = crel;
    rename_we = rwe; rename_rd = rrd; rename_tag = rtag;
    rs1_addr = a1; rs2_addr = a2;
    #2;
  endtask

  task automatic checkOutput(input string step);
    check_eq({step, ".rs1_value"}, rs1_value, exp_value(rs1_addr));
    check_eq({step, ".rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
    check_eq({step, ".rs1_tag"}, 32'(rs1_tag), 32'(exp_tag(rs1_addr)));
    check_eq({step, ".rs2_value"}, rs2_value, exp_value(rs2_addr));
    check_eq({step, ".rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
    check_eq({step, ".rs2_tag"}, 32'(rs2_tag), 32'(exp_tag(rs2_addr)));
    check_eq({step, ".commit_busy"}, 32'(commit_busy), 32'(commit_rd == 0 ? 1'b0 : m_bsy[commit_rd]));
    check_eq({step, ".commit_tag"}, 32'(commit_tag), 32'(commit_rd == 0 ? '0 : m_tag[commit_rd]));
  endtask

  // Model a clock edge: commit, then release, then rename, with clear dropping every busy bit.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_bsy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      if (commit_we && commit_rd != 0) begin
        m_val[commit_rd] = commit_data;
        if (commit_release) m_bsy[commit_rd] = 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) m_bsy[i] = 1'b0;
      end else if (rename_we && rename_rd != 0) begin
        m_bsy[rename_rd] = 1'b1;
        m_tag[rename_rd] = rename_tag;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_bsy[i] = 1'b0; m_tag[i] = '0;
    end

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();

    applyStimulus(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("reset");
    check_eq("reset.x5_value", rs1_value, 32'h0);
    check_eq("reset.x5_busy", 32'(rs1_busy), 32'h0);
    check_eq("reset.commit_busy", 32'(commit_busy), 32'h0);
    cycle();

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5, 4'd3, 5, 0);
    checkOutput("rename_same_cycle");
    check_eq("rename_same_cycle.x5_busy", 32'(rs1_busy), 32'h0);
    cycle();

    applyStimulus(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("rename_next");
    check_eq("rename_next.x5_busy", 32'(rs1_busy), 32'h1);
    check_eq("rename_next.x5_tag", 32'(rs1_tag), 32'h3);
    check_eq("rename_next.commit_tag", 32'(commit_tag), 32'h3);
    cycle();

    applyStimulus(0, 1, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 5, 5);
    checkOutput("commit_x5");
    check_eq("commit_x5.value", rs1_value, bypass_on() ? 32'hDEADBEEF : 32'h0);
    check_eq("commit_x5.busy", 32'(rs1_busy), bypass_on() ? 32'h0 : 32'h1);
    cycle();

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("after_commit");
    check_eq("after_commit.value", rs1_value, 32'hDEADBEEF);
    check_eq("after_commit.busy", 32'(rs1_busy), 32'h0);
    check_eq("after_commit.tag_kept", 32'(rs1_tag), 32'h3);
    cycle();

    applyStimulus(0, 1, 0, 1, 7, 32'h11, 1, 1, 7, 4'd9, 7, 0);
    checkOutput("rename_vs_release");
    cycle();
    applyStimulus(0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("rename_wins");
    check_eq("rename_wins.busy", 32'(rs1_busy), 32'h1);
    check_eq("rename_wins.tag", 32'(rs1_tag), 32'h9);
    check_eq("rename_wins.value", rs1_value, 32'h11);
    cycle();

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 1, 4'd2, 0, 0);
    cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, 4'd4, 1, 2);
    checkOutput("pre_clear");
    cycle();
    applyStimulus(0, 1, 1, 1, 1, 32'h40, 0, 1, 3, 4'd5, 1, 2);
    checkOutput("clear_cycle");
    cycle();
    applyStimulus(0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 2);
    checkOutput("after_clear");
    check_eq("after_clear.x1_busy", 32'(rs1_busy), 32'h0);
    check_eq("after_clear.x2_busy", 32'(rs2_busy), 32'h0);
    check_eq("after_clear.x1_value", rs1_value, 32'h40);
    check_eq("after_clear.x2_tag_kept", 32'(rs2_tag), 32'h4);
    check_eq("after_clear.x3_dropped", 32'(commit_busy), 32'h0);
    cycle();

    applyStimulus(0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 1, 0, 4'hF, 0, 0);
    checkOutput("x0_write");
    cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_read");
    check_eq("x0_read.value", rs1_value, 32'h0);
    check_eq("x0_read.busy", 32'(rs1_busy), 32'h0);
    check_eq("x0_read.tag", 32'(rs1_tag), 32'h0);
    cycle();

    applyStimulus(0, 0, 0, 1, 4, 32'h1234, 1, 1, 4, 4'd6, 4, 0);
    checkOutput("frozen");
    cycle();
    applyStimulus(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("after_freeze");
    check_eq("after_freeze.x4_value", rs1_value, 32'h0);
    check_eq("after_freeze.x4_busy", 32'(commit_busy), 32'h0);
    cycle();

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 15) == 0),
                    1'($urandom),
                    5'($urandom_range(0, 7)),
                    $urandom,
                    1'($urandom),
                    1'($urandom),
                    5'($urandom_range(0, 7)),
                    4'($urandom),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)));
      checkOutput("random");
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
